// File: rtl/threewire_pkg.sv
// Shared types and constants for the three-wire slave.
package threewire_pkg;

    localparam int ADDR_BITS_DEF = 10;
    localparam int DATA_BITS_DEF = 32;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_RW,
        ST_RX_ADDR,
        ST_RX_WDATA,
        ST_TURNAROUND,
        ST_TX_RDATA,
        ST_DONE
    } tw_state_t;

endpackage

// File: rtl/threewire_sync.sv
// Parameterised-width two-flop synchronizer with per-bit reset levels.
module threewire_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/threewire_slave.sv
// Three-wire (clk/cs/data) register-bus slave.
// Define THREEWIRE_SLAVE_SYNC_EN to add 2-flop input synchronizers.
module threewire_slave
    import threewire_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_tw_clock,
    input  logic                 in_tw_cs,
    inout  wire                  io_tw_data,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic [DATA_BITS-1:0] out_wr_data,
    output logic                 out_wr_strobe,
    output logic                 out_rd_req,
    input  logic [DATA_BITS-1:0] in_rd_data,
    output logic                 out_busy,
    output logic                 out_abort
);

    localparam int MAXB = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
    localparam int CW   = $clog2(MAXB);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BITS - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);

    // {clk, cs, data}; idle levels clk=0, cs=1
    localparam logic [2:0] BUS_IDLE = 3'b010;

    logic [2:0] bus_raw;
    logic [2:0] bus_s;
    logic       clk_s, cs_s, data_s, clk_d;
    logic       rise, fall;

    assign bus_raw = {in_tw_clock, in_tw_cs, io_tw_data};

`ifdef THREEWIRE_SLAVE_SYNC_EN
    threewire_sync #(
        .WIDTH   (3),
        .RST_VAL (BUS_IDLE)
    ) u_sync (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .d      (bus_raw),
        .q      (bus_s)
    );
`else
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) bus_s <= BUS_IDLE;
        else        bus_s <= bus_raw;
    end
`endif

    assign {clk_s, cs_s, data_s} = bus_s;
    assign rise = clk_s & ~clk_d;
    assign fall = ~clk_s & clk_d;

    tw_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 rw, rw_n;
    logic [ADDR_BITS-1:0] addr, addr_n;
    logic [DATA_BITS-1:0] wdata, wdata_n;
    logic [DATA_BITS-1:0] rdata;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
    logic                 dout, dout_n;
    logic                 oe, oe_n;
    logic                 seen_fall, seen_fall_n;
    logic                 wr_stb, wr_stb_n;
    logic                 rd_req, rd_req_n;
    logic                 abort, abort_n;
    logic                 rd_d1;
    logic [1:0]           settle;
    logic                 armed;
    logic                 active;

    assign active = (state != ST_IDLE) && (state != ST_DONE);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rw_n        = rw;
        addr_n      = addr;
        wdata_n     = wdata;
        tx_sh_n     = tx_sh;
        dout_n      = dout;
        oe_n        = oe;
        seen_fall_n = seen_fall;
        wr_stb_n    = 1'b0;
        rd_req_n    = 1'b0;
        abort_n     = 1'b0;
        if (active && cs_s) begin
            state_n = ST_IDLE;
            oe_n    = 1'b0;
            abort_n = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (armed && !cs_s) begin
                        state_n = ST_RX_RW;
                        cnt_n   = '0;
                    end
                end
                ST_RX_RW: begin
                    if (rise) begin
                        rw_n    = data_s;
                        cnt_n   = '0;
                        state_n = ST_RX_ADDR;
                    end
                end
                ST_RX_ADDR: begin
                    if (rise) begin
                        addr_n = {addr[ADDR_BITS-2:0], data_s};
                        cnt_n  = cnt + 1'b1;
                        if (cnt == ADDR_LAST) begin
                            cnt_n = '0;
                            if (rw == RW_WRITE) begin
                                state_n = ST_RX_WDATA;
                            end else begin
                                state_n     = ST_TURNAROUND;
                                rd_req_n    = 1'b1;
                                seen_fall_n = 1'b0;
                            end
                        end
                    end
                end
                ST_RX_WDATA: begin
                    if (rise) begin
                        wdata_n = {wdata[DATA_BITS-2:0], data_s};
                        cnt_n   = cnt + 1'b1;
                        if (cnt == DATA_LAST) begin
                            state_n  = ST_DONE;
                            wr_stb_n = 1'b1;
                        end
                    end
                end
                ST_TURNAROUND: begin
                    // master releases the line on this falling edge
                    if (fall) begin
                        seen_fall_n = 1'b1;
                    end else if (rise && seen_fall) begin
                        oe_n    = 1'b1;
                        dout_n  = rdata[DATA_BITS-1];
                        tx_sh_n = rdata << 1;
                        cnt_n   = CW'(1);
                        state_n = ST_TX_RDATA;
                    end
                end
                ST_TX_RDATA: begin
                    if (rise) begin
                        dout_n  = tx_sh[DATA_BITS-1];
                        tx_sh_n = tx_sh << 1;
                        cnt_n   = cnt + 1'b1;
                        if (cnt == DATA_LAST) state_n = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (cs_s) begin
                        state_n = ST_IDLE;
                        oe_n    = 1'b0;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    oe_n    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rw        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rdata     <= '0;
            tx_sh     <= '0;
            dout      <= 1'b0;
            oe        <= 1'b0;
            seen_fall <= 1'b0;
            wr_stb    <= 1'b0;
            rd_req    <= 1'b0;
            abort     <= 1'b0;
            rd_d1     <= 1'b0;
            clk_d     <= 1'b0;
            settle    <= '0;
            armed     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rw        <= rw_n;
            addr      <= addr_n;
            wdata     <= wdata_n;
            tx_sh     <= tx_sh_n;
            dout      <= dout_n;
            oe        <= oe_n;
            seen_fall <= seen_fall_n;
            wr_stb    <= wr_stb_n;
            rd_req    <= rd_req_n;
            abort     <= abort_n;
            rd_d1     <= rd_req;
            clk_d     <= clk_s;
            if (rd_d1) rdata <= in_rd_data;
            // ignore reset-value cs until the input pipeline has refilled
            if (settle != 2'd3) settle <= settle + 2'd1;
            armed     <= armed | ((settle == 2'd3) & cs_s);
        end
    end

    assign io_tw_data    = oe ? dout : 1'bz;
    assign out_addr      = addr;
    assign out_wr_data   = wdata;
    assign out_wr_strobe = wr_stb;
    assign out_rd_req    = rd_req;
    assign out_abort     = abort;
    assign out_busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_threewire_slave.sv
// Self-checking bench for threewire_slave: bus master plus
// transaction-level expectation queue.
module tb_threewire_slave;

    localparam int AB = 10;
    localparam int DB = 32;
`ifdef THREEWIRE_SLAVE_SYNC_EN
    localparam int H   = 4;
    localparam int LAT = 3;
`else
    localparam int H   = 2;
    localparam int LAT = 2;
`endif

    logic          in_clk = 1'b0;
    logic          in_rst = 1'b1;
    logic          tw_clk = 1'b0;
    logic          tw_cs  = 1'b1;
    logic          m_oe   = 1'b0;
    logic          m_dout = 1'b0;
    logic [DB-1:0] rd_data = '0;
    wire           tw_data;
    logic [AB-1:0] out_addr;
    logic [DB-1:0] out_wr_data;
    logic          out_wr_strobe, out_rd_req, out_busy, out_abort;

    pullup pu (tw_data);
    assign tw_data = m_oe ? m_dout : 1'bz;

    threewire_slave #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_tw_clock   (tw_clk),
        .in_tw_cs      (tw_cs),
        .io_tw_data    (tw_data),
        .out_addr      (out_addr),
        .out_wr_data   (out_wr_data),
        .out_wr_strobe (out_wr_strobe),
        .out_rd_req    (out_rd_req),
        .in_rd_data    (rd_data),
        .out_busy      (out_busy),
        .out_abort     (out_abort)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        int            kind;   // 0 write, 1 read request, 2 abort
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  last_rise = 0;
    int  mk;
    ev_t me;

    always @(posedge in_clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge in_clk) begin
        if (out_wr_strobe || out_rd_req || out_abort) begin
            mk = out_wr_strobe ? 0 : (out_rd_req ? 1 : 2);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got kind %0d want none", mk);
            end else begin
                me = exp_q.pop_front();
                chk("pulse_kind", 64'(mk), 64'(me.kind));
                chk("pulse_single", 64'(out_wr_strobe + out_rd_req + out_abort), 64'(1));
                if (me.kind != 2) begin
                    chk("ev_addr", 64'(out_addr), 64'(me.addr));
                    chk("ev_latency", 64'(cyc - last_rise), 64'(LAT));
                end
                if (me.kind == 0) chk("ev_wdata", 64'(out_wr_data), 64'(me.data));
            end
        end
    end

    task automatic wait_c(int n);
        repeat (n) @(negedge in_clk);
    endtask

    task automatic bit_out(logic b);
        m_oe   = 1'b1;
        m_dout = b;
        wait_c(H);
        tw_clk    = 1'b1;
        last_rise = cyc;
        wait_c(H);
        tw_clk = 1'b0;
    endtask

    task automatic bit_in(output logic b);
        tw_clk = 1'b1;
        wait_c(H);
        tw_clk = 1'b0;
        wait_c(H);
        b = tw_data;
    endtask

    task automatic cs_start();
        tw_cs = 1'b0;
        wait_c(H);
    endtask

    task automatic cs_stop();
        tw_cs = 1'b1;
        m_oe  = 1'b0;
        wait_c(2 * H);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) wait_c(1);
        chk("drain_pending", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    task automatic send_hdr(logic rw, logic [AB-1:0] a);
        cs_start();
        bit_out(rw);
        for (int i = AB - 1; i >= 0; i--) bit_out(a[i]);
    endtask

    task automatic do_write(logic [AB-1:0] a, logic [DB-1:0] d);
        exp_q.push_back('{0, a, d});
        cs_start();
        bit_out(1'b1);
        chk("busy_in_frame", 64'(out_busy), 64'(1));
        for (int i = AB - 1; i >= 0; i--) bit_out(a[i]);
        for (int i = DB - 1; i >= 0; i--) bit_out(d[i]);
        cs_stop();
        drain();
        chk("wr_io_idle", 64'(tw_data), 64'(1));
        chk("wr_busy_idle", 64'(out_busy), 64'(0));
    endtask

    task automatic do_read(logic [AB-1:0] a, logic [DB-1:0] d,
                           output logic [DB-1:0] got);
        logic b;
        got = '0;
        rd_data = d;
        exp_q.push_back('{1, a, d});
        send_hdr(1'b0, a);
        m_oe = 1'b0;
        wait_c(H);
        chk("turn_hiz", 64'(tw_data), 64'(1));
        for (int i = 0; i < DB; i++) begin
            bit_in(b);
            got = {got[DB-2:0], b};
        end
        cs_stop();
        drain();
        if (d[0] == 1'b0) chk("rd_io_release", 64'(tw_data), 64'(1));
    endtask

    logic [DB-1:0] got, rd_v, wd_v;
    logic [AB-1:0] ad_v;
    logic          bx;

    initial begin
        wait_c(3);
        chk("rst_wr_strobe", 64'(out_wr_strobe), 64'(0));
        chk("rst_rd_req", 64'(out_rd_req), 64'(0));
        chk("rst_busy", 64'(out_busy), 64'(0));
        chk("rst_abort", 64'(out_abort), 64'(0));
        chk("rst_addr", 64'(out_addr), 64'(0));
        chk("rst_wdata", 64'(out_wr_data), 64'(0));
        chk("rst_io_hiz", 64'(tw_data), 64'(1));
        in_rst = 1'b0;
        wait_c(6);

        do_write(10'h2A5, 32'hDEADBEEF);
        do_read(10'h011, 32'h12345678, got);
        chk("rd_literal", 64'(got), 64'h12345678);

        exp_q.push_back('{2, '0, '0});
        cs_start();
        bit_out(1'b1);
        for (int i = 0; i < 5; i++) bit_out(1'($urandom_range(1)));
        cs_stop();
        drain();
        chk("abort_busy", 64'(out_busy), 64'(0));
        do_write(10'h155, 32'hA5A50F0F);

        for (int n = 0; n < 10; n++) begin
            ad_v = AB'($urandom);
            wd_v = $urandom;
            if ($urandom_range(1) == 1) begin
                do_write(ad_v, wd_v);
            end else begin
                do_read(ad_v, wd_v, got);
                chk("rd_random", 64'(got), 64'(wd_v));
            end
        end

        rd_data = '0;
        ad_v = AB'($urandom);
        exp_q.push_back('{1, ad_v, '0});
        send_hdr(1'b0, ad_v);
        m_oe = 1'b0;
        wait_c(H);
        for (int i = 0; i < 4; i++) bit_in(bx);
        chk("tx_driving", 64'(tw_data), 64'(0));
        in_rst = 1'b1;
        #1;
        chk("rst_tx_io_hiz", 64'(tw_data), 64'(1));
        chk("rst_tx_busy", 64'(out_busy), 64'(0));
        chk("rst_tx_addr", 64'(out_addr), 64'(0));
        chk("rst_tx_req", 64'(out_rd_req), 64'(0));
        wait_c(2);
        in_rst = 1'b0;
        for (int i = 0; i < 4; i++) bit_out(1'b1);
        chk("post_rst_no_frame", 64'(out_busy), 64'(0));
        cs_stop();
        drain();
        ad_v = AB'($urandom);
        wd_v = $urandom;
        do_write(ad_v, wd_v);
        do_read(10'h3C3, 32'h0F1E2D3C, got);
        chk("rd_final", 64'(got), 64'h0F1E2D3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/threewire_slave.md
THREEWIRE_SLAVE -- requirements
Module: threewire_slave

Interface
REQ-001 Parameter ADDR_BITS, default 10, address field width in bits.
REQ-002 Parameter DATA_BITS, default 32, data field width in bits.
REQ-003 in_clk  input  1  system clock; all logic on its rising edge.
REQ-004 in_rst  input  1  reset, asynchronous, active-high.
REQ-005 in_tw_clock  input  1  3w bus clock from master; may run continuously.
REQ-006 in_tw_cs  input  1  3w chip select, active-low.
REQ-007 io_tw_data  inout  1  3w bidirectional data; high-Z unless the slave is driving read data.
REQ-008 out_addr  output  ADDR_BITS  received address; valid while out_wr_strobe or out_rd_req is high.
REQ-009 out_wr_data  output  DATA_BITS  received write data; valid with out_wr_strobe.
REQ-010 out_wr_strobe  output  1  single-cycle pulse: write transaction complete.
REQ-011 out_rd_req  output  1  single-cycle pulse: read address received.
REQ-012 in_rd_data  input  DATA_BITS  read data from register file.
REQ-013 out_busy  output  1  high from cs falling edge detected until return to idle.
REQ-014 out_abort  output  1  single-cycle pulse when cs rises before the frame completes.

Function
REQ-015 Bus inputs SHALL be registered in in_clk; rising/falling tw-clock edges SHALL be detected from the registered copy.
REQ-016 Frame: bit 1 = R/W (1 = write), then ADDR_BITS address bits MSB first; write frame adds DATA_BITS data bits MSB first.
REQ-017 Slave SHALL sample io_tw_data on each detected tw-clock rising edge while cs is low.
REQ-018 States: IDLE, RX_RW, RX_ADDR, RX_WDATA, TURNAROUND, TX_RDATA, DONE.
REQ-019 IDLE -> RX_RW on cs low; RX_RW -> RX_ADDR after 1 sampled bit; RX_ADDR -> RX_WDATA (W) or TURNAROUND (R) after ADDR_BITS samples.
REQ-020 RX_WDATA -> DONE after DATA_BITS samples; out_wr_strobe SHALL pulse exactly 1 cycle, 1 in_clk after the last sample.
REQ-021 On entry to TURNAROUND, out_rd_req SHALL pulse 1 cycle; in_rd_data SHALL be latched exactly 2 in_clk cycles after that pulse.
REQ-022 TURNAROUND: slave SHALL keep io high-Z for the next tw-clock falling edge (master release), then drive the latched MSB on the following rising edge and enter TX_RDATA.
REQ-023 TX_RDATA: each subsequent rising edge SHALL shift out the next bit; after DATA_BITS bits driven, enter DONE and hold the last bit until cs rises.
REQ-024 DONE -> IDLE on cs high; io_tw_data SHALL be high-Z within 1 in_clk of detected cs high.
REQ-025 cs high in any state other than IDLE/DONE SHALL return to IDLE, release io, pulse out_abort, suppress strobe/req.
REQ-026 Rising edges while cs high SHALL be ignored; bit counter width = clog2(max(ADDR_BITS, DATA_BITS)).
REQ-027 tw-clock half-period SHALL be >= 4 in_clk cycles (SYNC_EN defined) or >= 2 (undefined); faster clocks are unsupported.

Reset
REQ-028 On in_rst: state IDLE, io high-Z, out_addr/out_wr_data 0, out_wr_strobe/out_rd_req/out_busy/out_abort 0, synchronizer flops = idle levels (cs 1, clk 0).
REQ-029 Reset mid-frame SHALL discard the frame; the next frame starts only after cs is seen high then low.

Configuration
REQ-030 Macro THREEWIRE_SLAVE_SYNC_EN defined: clk, cs, data pass 2-flop synchronizers before edge detection (latency +1 cycle).
REQ-031 Undefined: single register stage only; all cycle latencies in REQ-020/021 unchanged relative to the detected edge.

Structure
REQ-032 Shared package threewire_pkg: state encoding, R/W bit constants, default ADDR_BITS/DATA_BITS; reuse existing _clog2/_max builtins.
REQ-033 One sub-module threewire_sync (parameterised-width 2-flop synchronizer) instantiated only under THREEWIRE_SLAVE_SYNC_EN.

Verification
REQ-034 Write addr 0x2A5, data 0xDEADBEEF -> one out_wr_strobe, out_addr=0x2A5, out_wr_data=0xDEADBEEF; io never driven.
REQ-035 Read addr 0x011, in_rd_data=0x12345678 -> one out_rd_req with out_addr=0x011; bus bits MSB-first = 0x12345678; io high-Z in turnaround and after cs high.
REQ-036 cs raised after 5 address bits -> out_abort pulse, no strobe/req, state IDLE; next full write frame decoded correctly.
REQ-037 in_rst asserted during TX_RDATA -> io high-Z immediately; outputs at reset values.
REQ-038 Back-to-back write then read with cs high for one tw period -> both decoded, no cross-contamination.
REQ-039 Run REQ-034/035 with and without THREEWIRE_SLAVE_SYNC_EN at minimum legal half-period -> identical decoded results.
